// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
// Shared definitions for the fetch stage: opcode constants, the bubble
// instruction, and the fetch FSM state type.
// Ports: none (package).
// Optional feature macro used by importers: FETCH_PERF_CNT_EN.
package fetch_stage_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_INC = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0110;
    localparam logic [3:0] OP_ST  = 4'b1010;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_RES = 4'b1100;
    localparam logic [3:0] OP_LD  = 4'b1101;
    localparam logic [3:0] OP_JMP = 4'b1111;

    // All-zero word: decodes as NOP at any instruction width up to 64 bits.
    localparam logic [63:0] BUBBLE_INSTR = 64'h0;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt
// 32-bit saturating event counter; holds at all-ones instead of wrapping.
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset (clears count)
//   inc    in   count one event this cycle
//   count  out  current count
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch: drives the instruction memory from pc, registers the
// returned word for decode, handles stall and redirect from downstream.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
// Ports:
//   clk             in   clock
//   rst_n           in   synchronous active-low reset
//   imem_addr       out  instruction address (= pc)
//   imem_rdata      in   instruction word, combinational read of imem_addr
//   stall           in   hold request from hazard logic
//   redirect_valid  in   taken JMP/BEQ resolved downstream
//   redirect_pc     in   redirect target
//   id_instr        out  registered instruction for decode
//   id_opcode       out  top 4 bits of id_instr
//   id_pc           out  address of id_instr
//   id_valid        out  id_instr is a real instruction
//   perf_fetched    out  (FETCH_PERF_CNT_EN) fetched-instruction count
//   perf_flushed    out  (FETCH_PERF_CNT_EN) redirect count
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | single cycle after reset; outputs are bubbles, pc held at 0
// RUN   | normal fetch: redirect > stall > fetch-and-increment
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic [3:0]         id_opcode,
    output logic [PC_W-1:0]    id_pc,
    output logic               id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
`endif
);

    fetch_state_e       state, state_nxt;
    logic [PC_W-1:0]    pc, pc_nxt;
    logic [INSTR_W-1:0] id_instr_nxt;
    logic [PC_W-1:0]    id_pc_nxt;
    logic               id_valid_nxt;
    logic               take_fetch;
    logic               take_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            pc       <= '0;
            id_instr <= '0;
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            id_instr <= id_instr_nxt;
            id_pc    <= id_pc_nxt;
            id_valid <= id_valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        id_instr_nxt = id_instr;
        id_pc_nxt    = id_pc;
        id_valid_nxt = id_valid;
        take_fetch   = 1'b0;
        take_flush   = 1'b0;
        unique case (state)
            ST_BOOT: begin
                // redirect and stall are not looked at here
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    take_flush   = 1'b1;
                    pc_nxt       = redirect_pc;
                    id_instr_nxt = BUBBLE_INSTR[INSTR_W-1:0];
                    id_pc_nxt    = pc;
                    id_valid_nxt = 1'b0;
                end else if (!stall) begin
                    take_fetch   = 1'b1;
                    pc_nxt       = pc + 1'b1;
                    id_instr_nxt = imem_rdata;
                    id_pc_nxt    = pc;
                    id_valid_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    assign imem_addr = pc;
    assign id_opcode = id_instr[INSTR_W-1 -: 4];

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_cnt u_cnt_fetched (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (take_fetch),
        .count (perf_fetched)
    );

    fetch_perf_cnt u_cnt_flushed (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (take_flush),
        .count (perf_flushed)
    );
`else
    logic unused_take;
    assign unused_take = take_fetch ^ take_flush;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program-counter and instruction-address width.
REQ-002 SHALL have parameter INSTR_W, default 16, meaning instruction width; the opcode is bits [INSTR_W-1:INSTR_W-4].
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port imem_addr  output  PC_W  instruction memory address, equal to the current pc.
REQ-006 SHALL have port imem_rdata  input  INSTR_W  instruction memory data; a combinational read of imem_addr in the same cycle.
REQ-007 SHALL have port stall  input  1  hold request from the hazard logic.
REQ-008 SHALL have port redirect_valid  input  1  a taken JMP or BEQ resolved downstream.
REQ-009 SHALL have port redirect_pc  input  PC_W  redirect target address.
REQ-010 SHALL have port id_instr  output  INSTR_W  registered instruction for decode.
REQ-011 SHALL have port id_opcode  output  4  equal to id_instr[INSTR_W-1:INSTR_W-4]; feeds the control unit opcode input.
REQ-012 SHALL have port id_pc  output  PC_W  address of id_instr.
REQ-013 SHALL have port id_valid  output  1  id_instr is a real instruction, not a bubble.

Function
REQ-014 SHALL implement a two-state FSM: BOOT and RUN.
REQ-015 BOOT SHALL last exactly one cycle after rst_n deasserts: outputs stay bubbles, pc stays 0, and the next state is RUN unconditionally.
REQ-016 In RUN, when redirect_valid=1, the block SHALL set pc to redirect_pc, and id_instr/id_valid SHALL become the bubble (instr 0, NOP opcode 0000, valid 0); id_pc SHALL take the old pc.
REQ-017 In RUN, when redirect_valid=0 and stall=1, pc, id_instr, id_pc and id_valid SHALL all hold.
REQ-018 In RUN, when redirect_valid=0 and stall=0, the block SHALL set id_instr to imem_rdata, id_pc to pc, id_valid to 1, and pc to pc+1.
REQ-019 When redirect_valid and stall are both 1, redirect SHALL win and stall SHALL be ignored for that cycle.
REQ-020 pc increment SHALL wrap modulo 2^PC_W (pc=2^PC_W-1 -> 0) with no flag.
REQ-021 redirect_valid SHALL be ignored in BOOT.
REQ-022 Fetch-to-decode latency SHALL be exactly 1 cycle; after a redirect, the first target instruction SHALL appear in id_instr 2 cycles after the redirect edge (one bubble).

Reset
REQ-023 When rst_n=0 at a clock edge, the block SHALL set pc=0, state=BOOT, id_instr=0, id_pc=0, id_valid=0, overriding stall and redirect.
REQ-024 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state; no instruction SHALL survive reset.

Configuration
REQ-025 Macro FETCH_PERF_CNT_EN SHALL, when defined, add outputs perf_fetched (32 bits; count of cycles with REQ-018 taken) and perf_flushed (32 bits; count of redirects taken in RUN).
REQ-026 Both counters SHALL reset to 0, saturate at 2^32-1 and never wrap.
REQ-027 Without FETCH_PERF_CNT_EN, the ports and counter logic SHALL be absent, with identical behaviour otherwise.

Structure
REQ-028 A shared package SHALL hold the opcode constants (NOP 0000, ADD 0001, MUL 0010, INC 0011, XOR 0100, CMP 0110, ST 1010, BEQ 1011, RES 1100, LD 1101, JMP 1111), the bubble instruction constant, and the FSM state typedef.
REQ-029 The perf counters SHALL be one sub-module, fetch_perf_cnt, instantiated twice under FETCH_PERF_CNT_EN; everything else SHALL be flat.

Verification
REQ-030 Reset then free-run, with imem[n]=16'h1000+n: first cycle after reset is BOOT with id_valid=0; then id_pc=0,1,2 in consecutive cycles with id_instr=16'h1000,16'h1001,16'h1002.
REQ-031 Stall for 3 cycles while id_pc=5: id_pc stays 5 and id_instr stays 16'h1005 for 3 cycles; after release, id_pc=6 on the next edge.
REQ-032 Redirect to 8'h40 while pc=7: next cycle id_valid=0 and id_opcode=0000; the following cycle id_pc=8'h40 with id_valid=1.
REQ-033 stall=1 and redirect_valid=1 to 8'h10 in the same cycle: redirect taken, then id_pc=8'h10 two cycles later.
REQ-034 pc reaches 8'hFF with no stall: id_pc=8'hFF, then id_pc=8'h00 next cycle.
REQ-035 rst_n=0 mid-stall with FETCH_PERF_CNT_EN defined: all outputs and both counters become 0 at the next edge; BOOT then repeats REQ-030.
